pc_predict_unit: RTL and testbench
==================================

Name: pc_predict_unit

Overview:
- Parametrised next-PC generator with an integrated branch target buffer (BTB) and 2-bit saturating predictors.
- Owns the fetch PC register and predicts taken branches at fetch.
- Accepts jump redirects from decode and branch resolutions from execute; raises flushes on redirect.
- Keeps wrap-around performance counters for resolved branches and mispredicts.

Parameters:
WIDTH, 32, PC/target/counter width in bits
BTB_DEPTH, 16, number of BTB entries; power of 2, >=2; IDX_W = log2(BTB_DEPTH)
RESET_PC, 0, PC value loaded at reset

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
start  in  1  pulse; sets the sticky run flag
stall  in  1  hold PC (hazard)
jump_valid  in  1  decode holds j/jal/jr/taken-bex
jump_target  in  WIDTH  decode jump destination
res_valid  in  1  execute resolves a conditional branch this cycle
res_pc  in  WIDTH  PC of the resolving branch
res_taken  in  1  actual direction
res_target  in  WIDTH  actual taken target (pc+1+imm)
res_pred_taken  in  1  prediction carried with that branch
res_pred_target  in  WIDTH  predicted target carried with that branch
fetch_pc  out  WIDTH  current PC register
pred_taken  out  1  BTB predicts fetch_pc is a taken branch
pred_target  out  WIDTH  predicted target (0 when pred_taken=0)
flush_branch  out  1  branch mispredict redirect this cycle
flush_jump  out  1  decode jump redirect this cycle
running  out  1  run flag
branch_count  out  WIDTH  resolved branches
mispredict_count  out  WIDTH  mispredicts

Behaviour:
- Reset (reset_n=0 at posedge): fetch_pc=RESET_PC; running=0; all BTB valid bits=0; both counters=0. Reset mid-operation discards all BTB state. Any pending redirect is dropped.
- running: set on a posedge with start=1; stays set until reset.
- While running=0:
  - PC holds.
  - res_*, jump_* and stall are ignored.
  - flush_* = 0; counters hold.
- BTB entry: valid, tag = pc[WIDTH-1:IDX_W], target[WIDTH], ctr[2].
- Lookup:
  - Combinational on fetch_pc, index = fetch_pc[IDX_W-1:0].
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1]. pred_target = pred_taken ? entry target : 0.
- Mispredict: mispredict = res_valid & running & ((res_taken != res_pred_taken) | (res_taken & res_pred_taken & res_target != res_pred_target)).
- Flush outputs (combinational, same cycle):
  - flush_branch = mispredict.
  - flush_jump = jump_valid & running & ~stall & ~mispredict.
- Next-PC priority, high to low:
  1. mispredict -> res_taken ? res_target : res_pc+1. Overrides stall.
  2. flush_jump -> jump_target.
  3. stall -> hold.
  4. pred_taken -> pred_target.
  5. Otherwise fetch_pc+1.
- All adds are modulo 2^WIDTH; PC wraps from all-ones to 0.
- BTB update (at posedge, when res_valid & running), index/tag from res_pc:
  - Hit: ctr saturating +1 if taken, -1 if not taken (bounds 0 and 3). If taken, target := res_target.
  - Miss & taken: allocate (overwriting any occupant): valid=1, tag, target=res_target, ctr=2.
  - Miss & not taken: no change.
- Lookup/update collision: a same-cycle lookup of the entry being written sees the old contents (read-before-write).
- Counters: branch_count += 1 per res_valid while running; mispredict_count += 1 per mispredict. Both wrap modulo 2^WIDTH.
- Stall does not block BTB updates or counters.

Test Plan:
- Reset, then start; no branches -> fetch_pc 0,1,2,3 on successive cycles; pred_taken=0; flush_*=0.
- No start after reset, stall=0 -> fetch_pc stays 0 for 10 cycles; res_valid pulses leave counters at 0.
- res_valid, res_pc=5, res_taken=1, res_target=20, res_pred_taken=0:
  - Same cycle: flush_branch=1.
  - Next cycle: fetch_pc=20; mispredict_count=1.
  - Later, fetch_pc=5 -> pred_taken=1, pred_target=20, next fetch_pc=20.
- Entry at pc 5 with ctr=2; resolve not-taken twice -> first resolve: ctr=1, mispredict, PC=6. At the next fetch of pc 5: pred_taken=0. Five taken resolves -> ctr saturates at 3.
- Same cycle stall=1, jump_valid=1 (target 40), mispredict to 30 -> flush_branch=1, flush_jump=0, fetch_pc=30 next cycle.
- BTB_DEPTH=4: allocate pc 2 (target 9), then pc 6 (target 11) with the same index -> lookup of pc 2 misses, pc 6 hits. With WIDTH=8 and fetch_pc=255 -> next fetch_pc=0.

Source files
------------

// File: rtl/pc_predict_unit.sv
// Fetch PC register with direct-mapped BTB and 2-bit counters; next PC and flushes are same-cycle combinational.
// Mispredict redirects override stall. Prediction lookup reads the BTB before any same-cycle update.
module pc_predict_unit #(
  parameter int               WIDTH     = 32,
  parameter int               BTB_DEPTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             jump_valid,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_pc,
  input  logic             res_taken,
  input  logic [WIDTH-1:0] res_target,
  input  logic             res_pred_taken,
  input  logic [WIDTH-1:0] res_pred_target,
  output logic [WIDTH-1:0] fetch_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  output logic             flush_branch,
  output logic             flush_jump,
  output logic             running,
  output logic [WIDTH-1:0] branch_count,
  output logic [WIDTH-1:0] mispredict_count
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = WIDTH - IDX_W;

  logic [WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
  logic                 running_q, running_d;
  logic [WIDTH-1:0]     branch_cnt_q, branch_cnt_d;
  logic [WIDTH-1:0]     mispred_cnt_q, mispred_cnt_d;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [WIDTH-1:0]     tgt_q [BTB_DEPTH];
  logic [1:0]           ctr_q [BTB_DEPTH];

  logic [IDX_W-1:0]     rd_idx, wr_idx;
  logic [TAG_W-1:0]     wr_tag;
  logic                 rd_hit, wr_hit, upd_en, mispredict;
  logic [1:0]           ctr_upd;

  assign rd_idx      = fetch_pc_q[IDX_W-1:0];
  assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == fetch_pc_q[WIDTH-1:IDX_W]);
  assign pred_taken  = rd_hit && ctr_q[rd_idx][1];
  assign pred_target = pred_taken ? tgt_q[rd_idx] : '0;

  assign wr_idx = res_pc[IDX_W-1:0];
  assign wr_tag = res_pc[WIDTH-1:IDX_W];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign upd_en = res_valid && running_q;

  // A correctly predicted direction with a stale target still counts as a mispredict.
  assign mispredict = upd_en &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && res_pred_taken && (res_target != res_pred_target)));

  assign flush_branch = mispredict;
  assign flush_jump   = jump_valid && running_q && !stall && !mispredict;

  always_comb begin
    ctr_upd = ctr_q[wr_idx];
    if (res_taken) begin
      if (ctr_q[wr_idx] != 2'd3) ctr_upd = ctr_q[wr_idx] + 2'd1;
    end else if (ctr_q[wr_idx] != 2'd0) begin
      ctr_upd = ctr_q[wr_idx] - 2'd1;
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    running_d     = running_q | start;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (running_q) begin
      if (mispredict)      fetch_pc_d = res_taken ? res_target : res_pc + WIDTH'(1);
      else if (flush_jump) fetch_pc_d = jump_target;
      else if (stall)      fetch_pc_d = fetch_pc_q;
      else if (pred_taken) fetch_pc_d = pred_target;
      else                 fetch_pc_d = fetch_pc_q + WIDTH'(1);
      if (res_valid)  branch_cnt_d  = branch_cnt_q + WIDTH'(1);
      if (mispredict) mispred_cnt_d = mispred_cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      running_q     <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      valid_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      running_q     <= running_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (upd_en) begin
        if (wr_hit) begin
          ctr_q[wr_idx] <= ctr_upd;
          if (res_taken) tgt_q[wr_idx] <= res_target;
        end else if (res_taken) begin
          valid_q[wr_idx] <= 1'b1;
          tag_q[wr_idx]   <= wr_tag;
          tgt_q[wr_idx]   <= res_target;
          ctr_q[wr_idx]   <= 2'd2;
        end
      end
    end
  end

  assign fetch_pc         = fetch_pc_q;
  assign running          = running_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;
endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: a default 32-bit/16-entry instance and an 8-bit/4-entry instance.
module tb_pc_predict_unit;
  logic        clock = 1'b0;
  logic        reset_n, start, stall, jump_valid, res_valid, res_taken, res_pred_taken;
  logic [31:0] jump_target, res_pc, res_target, res_pred_target;

  logic [31:0] fetch_pc, pred_target, branch_count, mispredict_count;
  logic        pred_taken, flush_branch, flush_jump, running;

  logic [7:0]  s_fetch_pc, s_pred_target, s_branch_count, s_mispredict_count;
  logic        s_pred_taken, s_flush_branch, s_flush_jump, s_running;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pc_predict_unit #(.WIDTH(32), .BTB_DEPTH(16), .RESET_PC(32'd0)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .flush_branch(flush_branch), .flush_jump(flush_jump), .running(running),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  pc_predict_unit #(.WIDTH(8), .BTB_DEPTH(4), .RESET_PC(8'd0)) u_small (
    .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
    .jump_valid(jump_valid), .jump_target(jump_target[7:0]),
    .res_valid(res_valid), .res_pc(res_pc[7:0]), .res_taken(res_taken), .res_target(res_target[7:0]),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target[7:0]),
    .fetch_pc(s_fetch_pc), .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .flush_branch(s_flush_branch), .flush_jump(s_flush_jump), .running(s_running),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; jump_valid = 0; jump_target = 0;
    res_valid = 0; res_pc = 0; res_taken = 0; res_target = 0;
    res_pred_taken = 0; res_pred_target = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    res_valid = 1; res_pc = pc; res_taken = tk; res_target = tgt;
    res_pred_taken = ptk; res_pred_target = ptgt;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (fetch_pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", fetch_pc); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
    total++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
    total++; if (pred_taken !== 1'b0 || flush_branch !== 1'b0 || flush_jump !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b%b exp=000", pred_taken, flush_branch, flush_jump); end
  endtask

  task automatic test_no_start();
    for (int i = 0; i < 10; i++) begin
      resolve(32'd5, 1'b1, 32'd20, 1'b0, 32'd0);
      jump_valid = 1; jump_target = 32'd40;
      #1;
      total++; if (flush_branch !== 1'b0 || flush_jump !== 1'b0) begin
        bad++; $display("FAIL idle_flush got=%b%b exp=00", flush_branch, flush_jump); end
      tick();
      total++; if (fetch_pc !== 32'd0) begin bad++; $display("FAIL idle_pc got=%0d exp=0", fetch_pc); end
    end
    clear_inputs();
    total++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      bad++; $display("FAIL idle_counts got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
  endtask

  task automatic test_sequential();
    do_start();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL seq_running got=%b exp=1", running); end
    for (int i = 0; i < 4; i++) begin
      total++; if (fetch_pc !== 32'(i) || pred_taken !== 1'b0 || flush_branch !== 1'b0 || flush_jump !== 1'b0) begin
        bad++; $display("FAIL seq_pc got=%0d pt=%b exp=%0d pt=0", fetch_pc, pred_taken, i); end
      tick();
    end
  endtask

  task automatic test_mispredict_alloc();
    do_reset(); do_start();
    resolve(32'd5, 1'b1, 32'd20, 1'b0, 32'd0);
    #1;
    total++; if (flush_branch !== 1'b1 || flush_jump !== 1'b0) begin
      bad++; $display("FAIL mp_flush got=%b%b exp=10", flush_branch, flush_jump); end
    tick(); clear_inputs();
    total++; if (fetch_pc !== 32'd20) begin bad++; $display("FAIL mp_pc got=%0d exp=20", fetch_pc); end
    total++; if (mispredict_count !== 32'd1 || branch_count !== 32'd1) begin
      bad++; $display("FAIL mp_counts got=%0d/%0d exp=1/1", branch_count, mispredict_count); end
    total++; if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
      bad++; $display("FAIL mp_nopred got=%b/%0d exp=0/0", pred_taken, pred_target); end
    jump_valid = 1; jump_target = 32'd5;
    #1;
    total++; if (flush_jump !== 1'b1) begin bad++; $display("FAIL jmp_flush got=%b exp=1", flush_jump); end
    tick(); clear_inputs();
    total++; if (fetch_pc !== 32'd5 || pred_taken !== 1'b1 || pred_target !== 32'd20) begin
      bad++; $display("FAIL btb_hit got=pc%0d pt=%b tgt=%0d exp=pc5 pt=1 tgt=20", fetch_pc, pred_taken, pred_target); end
    tick();
    total++; if (fetch_pc !== 32'd20) begin bad++; $display("FAIL pred_follow got=%0d exp=20", fetch_pc); end
  endtask

  task automatic test_counter();
    resolve(32'd5, 1'b0, 32'd0, 1'b1, 32'd20);
    #1;
    total++; if (flush_branch !== 1'b1) begin bad++; $display("FAIL nt_flush got=%b exp=1", flush_branch); end
    tick(); clear_inputs();
    total++; if (fetch_pc !== 32'd6 || mispredict_count !== 32'd2) begin
      bad++; $display("FAIL nt_pc got=%0d mp=%0d exp=6/2", fetch_pc, mispredict_count); end
    jump_valid = 1; jump_target = 32'd5; tick(); clear_inputs();
    total++; if (fetch_pc !== 32'd5 || pred_taken !== 1'b0) begin
      bad++; $display("FAIL weak_nt got=pc%0d pt=%b exp=pc5 pt=0", fetch_pc, pred_taken); end
    resolve(32'd5, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    total++; if (flush_branch !== 1'b0) begin bad++; $display("FAIL nt2_flush got=%b exp=0", flush_branch); end
    tick(); clear_inputs();
    total++; if (fetch_pc !== 32'd6) begin bad++; $display("FAIL nt2_pc got=%0d exp=6", fetch_pc); end
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      resolve(32'd5, 1'b1, 32'd20, 1'b1, 32'd20);
      tick();
    end
    resolve(32'd5, 1'b0, 32'd0, 1'b0, 32'd0);
    tick(); clear_inputs();
    total++; if (fetch_pc !== 32'd6) begin bad++; $display("FAIL stall_hold got=%0d exp=6", fetch_pc); end
    jump_valid = 1; jump_target = 32'd5; tick(); clear_inputs();
    total++; if (pred_taken !== 1'b1 || pred_target !== 32'd20) begin
      bad++; $display("FAIL saturate got=pt%b tgt=%0d exp=pt1 tgt=20", pred_taken, pred_target); end
    total++; if (branch_count !== 32'd9 || mispredict_count !== 32'd2) begin
      bad++; $display("FAIL cnt_mid got=%0d/%0d exp=9/2", branch_count, mispredict_count); end
    resolve(32'd5, 1'b0, 32'd0, 1'b0, 32'd0);
    tick(); clear_inputs();
    total++; if (fetch_pc !== 32'd20) begin bad++; $display("FAIL rbw_pred got=%0d exp=20", fetch_pc); end
    jump_valid = 1; jump_target = 32'd5; tick(); clear_inputs();
    total++; if (pred_taken !== 1'b0 || branch_count !== 32'd10) begin
      bad++; $display("FAIL ctr_down got=pt%b bc=%0d exp=pt0 bc=10", pred_taken, branch_count); end
  endtask

  task automatic test_priority();
    stall = 1; jump_valid = 1; jump_target = 32'd40;
    resolve(32'd7, 1'b1, 32'd30, 1'b0, 32'd0);
    #1;
    total++; if (flush_branch !== 1'b1 || flush_jump !== 1'b0) begin
      bad++; $display("FAIL prio_flush got=%b%b exp=10", flush_branch, flush_jump); end
    tick(); clear_inputs();
    total++; if (fetch_pc !== 32'd30 || mispredict_count !== 32'd3) begin
      bad++; $display("FAIL prio_pc got=%0d mp=%0d exp=30/3", fetch_pc, mispredict_count); end
    stall = 1; jump_valid = 1; jump_target = 32'd40;
    #1;
    total++; if (flush_jump !== 1'b0) begin bad++; $display("FAIL stall_jump got=%b exp=0", flush_jump); end
    tick(); clear_inputs();
    total++; if (fetch_pc !== 32'd30) begin bad++; $display("FAIL stall_jump_pc got=%0d exp=30", fetch_pc); end
    resolve(32'd30, 1'b1, 32'd50, 1'b1, 32'd50);
    #1;
    total++; if (pred_taken !== 1'b0 || flush_branch !== 1'b0) begin
      bad++; $display("FAIL collide got=pt%b fb=%b exp=pt0 fb=0", pred_taken, flush_branch); end
    tick(); clear_inputs();
    total++; if (fetch_pc !== 32'd31) begin bad++; $display("FAIL collide_pc got=%0d exp=31", fetch_pc); end
    jump_valid = 1; jump_target = 32'd30; tick(); clear_inputs();
    total++; if (pred_taken !== 1'b1 || pred_target !== 32'd50) begin
      bad++; $display("FAIL collide_after got=pt%b tgt=%0d exp=pt1 tgt=50", pred_taken, pred_target); end
  endtask

  task automatic test_small_alias_wrap();
    do_reset(); do_start();
    stall = 1;
    resolve(32'd2, 1'b1, 32'd9, 1'b1, 32'd9); tick();
    resolve(32'd6, 1'b1, 32'd11, 1'b1, 32'd11); tick();
    clear_inputs();
    jump_valid = 1; jump_target = 32'd2;
    #1;
    total++; if (s_flush_jump !== 1'b1) begin bad++; $display("FAIL s_jump got=%b exp=1", s_flush_jump); end
    tick(); clear_inputs();
    total++; if (s_fetch_pc !== 8'd2 || s_pred_taken !== 1'b0) begin
      bad++; $display("FAIL s_evicted got=pc%0d pt=%b exp=pc2 pt=0", s_fetch_pc, s_pred_taken); end
    jump_valid = 1; jump_target = 32'd6; tick(); clear_inputs();
    total++; if (s_pred_taken !== 1'b1 || s_pred_target !== 8'd11) begin
      bad++; $display("FAIL s_alias_hit got=pt%b tgt=%0d exp=pt1 tgt=11", s_pred_taken, s_pred_target); end
    total++; if (s_running !== 1'b1 || s_branch_count !== 8'd2 || s_mispredict_count !== 8'd0 || s_flush_branch !== 1'b0) begin
      bad++; $display("FAIL s_status got=r%b bc=%0d mp=%0d exp=r1 bc=2 mp=0", s_running, s_branch_count, s_mispredict_count); end
    jump_valid = 1; jump_target = 32'd255; tick(); clear_inputs();
    total++; if (s_fetch_pc !== 8'd255 || s_pred_taken !== 1'b0) begin
      bad++; $display("FAIL s_top got=pc%0d pt=%b exp=pc255 pt=0", s_fetch_pc, s_pred_taken); end
    tick();
    total++; if (s_fetch_pc !== 8'd0) begin bad++; $display("FAIL s_wrap got=%0d exp=0", s_fetch_pc); end
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    test_reset();
    test_no_start();
    test_sequential();
    test_mispredict_alloc();
    test_counter();
    test_priority();
    test_small_alias_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
